// File: rtl/imm_encoder.sv
// imm_encoder: splits a 32-bit constant into the shortest sequence of
// (imm16, extop) words that the immediate extender rebuilds exactly.
// Latency 1 cycle from accept to first word. Output words hold while
// out_ready is low; in_ready is withdrawn until the last word transfers.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     input handshake, in_data sampled on accept
//   in_data[31:0]         constant to encode
//   out_valid/out_ready   output handshake
//   out_imm16, out_extop  immediate field and extension op
//   out_last              final word of the current constant
//   out_two               word belongs to a lui+ori pair
//   stat_one, stat_two    one-/two-word encoding counters
//
// Build option: define IMM_ENC_STATS_EN to generate the statistics
// counters; otherwise stat_one/stat_two are constant zero.

`ifndef EXT_SIGN
`define EXT_SIGN 2'b00
`endif
`ifndef EXT_ZERO
`define EXT_ZERO 2'b01
`endif
`ifndef EXT_LUI
`define EXT_LUI 2'b10
`endif

module imm_encoder #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_imm16,
  output logic [1:0]        out_extop,
  output logic              out_last,
  output logic              out_two,
  output logic [STAT_W-1:0] stat_one,
  output logic [STAT_W-1:0] stat_two
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD1 = 2'd1,
    WORD2 = 2'd2
  } state_e;

  // Registered FSM state and output word.
  state_e      state_q;
  logic        out_valid_q;
  logic [15:0] imm_q;
  logic [1:0]  op_q;
  logic        last_q;
  logic        two_q;
  // Low half of a two-word constant, held until word 2 is presented.
  logic [15:0] lo_q;

  // First-word encoding of the constant currently on in_data.
  logic [15:0] acc_imm_d;
  logic [1:0]  acc_op_d;
  logic        acc_two_d;

  logic accept;
  logic xfer;

  assign xfer   = out_valid_q && out_ready;
  assign accept = in_valid && in_ready;

  // A new constant may enter as soon as the final word of the previous one
  // is leaving, which gives one word per cycle for single-word constants.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      WORD1:   in_ready = last_q && out_ready;
      WORD2:   in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Classification, first match wins. A sign-extendable value is checked
  // first so that overlaps (e.g. 0x0000_0000, 0x0000_7FFF) choose SIGN.
  always_comb begin
    acc_imm_d = in_data[15:0];
    acc_op_d  = `EXT_SIGN;
    acc_two_d = 1'b0;
    if (in_data[31:15] == {17{in_data[31]}}) begin
      acc_imm_d = in_data[15:0];
      acc_op_d  = `EXT_SIGN;
    end else if (in_data[31:16] == 16'h0000) begin
      acc_imm_d = in_data[15:0];
      acc_op_d  = `EXT_ZERO;
    end else if (in_data[15:0] == 16'h0000) begin
      acc_imm_d = in_data[31:16];
      acc_op_d  = `EXT_LUI;
    end else begin
      // lui of the high half; the zero-extended low half is ORed on later.
      acc_imm_d = in_data[31:16];
      acc_op_d  = `EXT_LUI;
      acc_two_d = 1'b1;
    end
  end

  // FSM with registered outputs. An accept can only coincide with the
  // transfer of a final word, so it takes priority over the drain-to-IDLE
  // branch and the sequencer never drops a bubble between constants.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      imm_q       <= 16'h0000;
      op_q        <= `EXT_SIGN;
      last_q      <= 1'b0;
      two_q       <= 1'b0;
      lo_q        <= 16'h0000;
    end else if (accept) begin
      state_q     <= WORD1;
      out_valid_q <= 1'b1;
      imm_q       <= acc_imm_d;
      op_q        <= acc_op_d;
      last_q      <= !acc_two_d;
      two_q       <= acc_two_d;
      lo_q        <= in_data[15:0];
    end else if (state_q == WORD1 && xfer && !last_q) begin
      state_q     <= WORD2;
      out_valid_q <= 1'b1;
      imm_q       <= lo_q;
      op_q        <= `EXT_ZERO;
      last_q      <= 1'b1;
      two_q       <= 1'b1;
    end else if (xfer) begin
      // Final word left with nothing new behind it; field values are kept
      // but no longer qualified.
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_imm16 = imm_q;
  assign out_extop = op_q;
  assign out_last  = last_q;
  assign out_two   = two_q;

`ifdef IMM_ENC_STATS_EN
  logic [STAT_W-1:0] stat_one_q;
  logic [STAT_W-1:0] stat_two_q;

  // Counted at accept time, so a constant aborted by reset mid-sequence is
  // still counted (and then cleared by that same reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_one_q <= '0;
      stat_two_q <= '0;
    end else if (accept) begin
      if (acc_two_d) begin
        stat_two_q <= stat_two_q + 1'b1;
      end else begin
        stat_one_q <= stat_one_q + 1'b1;
      end
    end
  end

  assign stat_one = stat_one_q;
  assign stat_two = stat_two_q;
`else
  assign stat_one = '0;
  assign stat_two = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed constants with hand-computed words,
// a queue of expected words, and a monitor that checks every transfer and
// that stalled words hold stable.

`ifndef EXT_SIGN
`define EXT_SIGN 2'b00
`endif
`ifndef EXT_ZERO
`define EXT_ZERO 2'b01
`endif
`ifndef EXT_LUI
`define EXT_LUI 2'b10
`endif

module tb_imm_encoder;

  localparam int STAT_W = 16;

  typedef struct packed {
    logic [15:0] imm;
    logic [1:0]  op;
    logic        last;
    logic        two;
  } word_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_imm16;
  logic [1:0]        out_extop;
  logic              out_last;
  logic              out_two;
  logic [STAT_W-1:0] stat_one;
  logic [STAT_W-1:0] stat_two;

  imm_encoder #(.STAT_W(STAT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm16 (out_imm16),
    .out_extop (out_extop),
    .out_last  (out_last),
    .out_two   (out_two),
    .stat_one  (stat_one),
    .stat_two  (stat_two)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  int    acc_cyc = 0;
  word_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected word per transfer; also verifies that a
  // stalled word is unchanged on the following cycle.
  word_t cur;
  word_t held;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    cur = '{imm: out_imm16, op: out_extop, last: out_last, two: out_two};
    if (!rst && stalled && out_valid) begin
      tests++;
      if (cur !== held) begin
        fails++;
        $display("FAIL stall_hold: got %h expected %h", cur, held);
      end
    end
    if (!rst && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got %h expected none", cur);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        if (cur !== e) begin
          fails++;
          $display("FAIL out_word: got %h expected %h", cur, e);
        end
      end
    end
    stalled = !rst && out_valid && !out_ready;
    held    = cur;
  end

  // Offer one constant and queue its expected words once accepted. Called
  // and returns just after a rising edge.
  task automatic send(input logic [31:0] d, input logic two,
                      input logic [15:0] i1, input logic [1:0] o1,
                      input logic [15:0] i2, input bit keep);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{imm: i1, op: o1, last: !two, two: two});
        if (two) exp_q.push_back('{imm: i2, op: `EXT_ZERO, last: 1'b1, two: 1'b1});
        acc_cyc = cyc;
        done    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected accept of %h", d);
    end
    if (!keep) begin
      in_valid = 1'b0;
      in_data  = 32'hA5A5_A5A5;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
    end
  endtask

  int first_acc;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_imm16", {16'd0, out_imm16}, 32'h0);
    chk("rst_extop", {30'd0, out_extop}, {30'd0, `EXT_SIGN});
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_two", {31'd0, out_two}, 32'd0);
    chk("rst_stat_one", {16'd0, stat_one}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency 1: word valid right after the accept edge.
    send(32'hFFFF_8000, 1'b0, 16'h8000, `EXT_SIGN, 16'h0, 1'b0);
    chk("latency1_valid", {31'd0, out_valid}, 32'd1);
    drain();

    send(32'h0000_ABCD, 1'b0, 16'hABCD, `EXT_ZERO, 16'h0, 1'b0);
    send(32'h1234_0000, 1'b0, 16'h1234, `EXT_LUI, 16'h0, 1'b0);
    send(32'h0000_7FFF, 1'b0, 16'h7FFF, `EXT_SIGN, 16'h0, 1'b0);
    send(32'h0000_0000, 1'b0, 16'h0000, `EXT_SIGN, 16'h0, 1'b0);
    send(32'h0000_8000, 1'b0, 16'h8000, `EXT_ZERO, 16'h0, 1'b0);
    send(32'h8000_0000, 1'b0, 16'h8000, `EXT_LUI, 16'h0, 1'b0);
    drain();

    // Two-word constant with the consumer stalled for three cycles.
    out_ready = 1'b0;
    send(32'h1234_5678, 1'b1, 16'h1234, `EXT_LUI, 16'h5678, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Back-to-back single-word constants with in_valid held high.
    send(32'h0000_0001, 1'b0, 16'h0001, `EXT_SIGN, 16'h0, 1'b1);
    first_acc = acc_cyc;
    send(32'hFFFF_FFFF, 1'b0, 16'hFFFF, `EXT_SIGN, 16'h0, 1'b0);
    chk("b2b_accept_gap", acc_cyc - first_acc, 32'd1);
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // Reset while word 2 is presented: the low half must never appear.
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 1'b1, 16'hDEAD, `EXT_LUI, 16'hBEEF, 1'b0);
    void'(exp_q.pop_back());  // word 2 is aborted by the reset below
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("abort_in_word2", {15'd0, out_imm16, out_last}, {15'd0, 16'hBEEF, 1'b1});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_words", {31'd0, out_valid}, 32'd0);

    // Statistics from a clean reset.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'h0000_0005, 1'b0, 16'h0005, `EXT_SIGN, 16'h0, 1'b0);
    send(32'h1234_5678, 1'b1, 16'h1234, `EXT_LUI, 16'h5678, 1'b0);
    send(32'h8000_0000, 1'b0, 16'h8000, `EXT_LUI, 16'h0, 1'b0);
    drain();
`ifdef IMM_ENC_STATS_EN
    chk("stat_one", {16'd0, stat_one}, 32'd2);
    chk("stat_two", {16'd0, stat_two}, 32'd1);
`else
    chk("stat_one", {16'd0, stat_one}, 32'd0);
    chk("stat_two", {16'd0, stat_two}, 32'd0);
`endif

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
